// File: rtl/uart_tx_formatter.sv
// uart_tx_formatter: turns a byte packet stream into one ASCII hex text line
// per packet ("3A F0:5\r\n"), with valid/ready handshakes on both sides.
// The character register is loaded together with each state change, so
// uart_tx_valid/uart_tx_byte are fully registered and hold steady on stalls.
module uart_tx_formatter #(
   parameter bit UPPERCASE = 1'b1,
   parameter bit SPACE_SEP = 1'b1,
   parameter bit CRLF      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tvalid,
   output logic       tready,
   input  logic [7:0] tdata,
   input  logic [3:0] tdatab,
   input  logic       tlast,
   output logic       uart_tx_valid,
   input  logic       uart_tx_ready,
   output logic [7:0] uart_tx_byte,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEXH,
      ST_HEXL,
      ST_SEP,
      ST_COLON,
      ST_BITS,
      ST_CR,
      ST_LF
   } state_t;

   // First state/character of the line terminator ("\r\n" or just "\n").
   localparam state_t     TERM_STATE = CRLF ? ST_CR : ST_LF;
   localparam logic [7:0] TERM_CHAR  = CRLF ? 8'h0D : 8'h0A;
   localparam int         ALPHA_BASE = UPPERCASE ? 'h41 : 'h61;

   state_t     state_reg;
   logic [7:0] data_reg;
   logic       last_reg;
   logic [3:0] datab_reg;
   logic       tx_valid_reg;
   logic [7:0] tx_byte_reg;

   // Nibble-to-ASCII table, fixed at elaboration by the letter case choice.
   logic [7:0] hex_lut [16];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_hex
         if (gi < 10) begin : g_digit
            assign hex_lut[gi] = 8'(48 + gi);
         end else begin : g_alpha
            assign hex_lut[gi] = 8'(ALPHA_BASE + gi - 10);
         end
      end
   endgenerate

   // A partial last byte (1..7 valid bits) gets the ":d" suffix; 0 and 8..15 mean full.
   logic has_suffix;
   assign has_suffix = ~datab_reg[3] & (datab_reg[2:0] != 3'd0);

   assign tready        = (state_reg == ST_IDLE) & ~rst;
   assign busy          = (state_reg != ST_IDLE);
   assign uart_tx_valid = tx_valid_reg;
   assign uart_tx_byte  = tx_byte_reg;

   // Line FSM: takes a byte in IDLE, then steps one character per output transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         data_reg     <= 8'h00;
         last_reg     <= 1'b0;
         datab_reg    <= 4'h0;
         tx_valid_reg <= 1'b0;
         tx_byte_reg  <= 8'h00;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (tvalid) begin
                  data_reg     <= tdata;
                  last_reg     <= tlast;
                  datab_reg    <= tdatab;
                  state_reg    <= ST_HEXH;
                  tx_valid_reg <= 1'b1;
                  tx_byte_reg  <= hex_lut[tdata[7:4]];
               end
            end
            ST_HEXH: begin
               if (uart_tx_ready) begin
                  state_reg   <= ST_HEXL;
                  tx_byte_reg <= hex_lut[data_reg[3:0]];
               end
            end
            ST_HEXL: begin
               if (uart_tx_ready) begin
                  if (!last_reg) begin
                     if (SPACE_SEP) begin
                        state_reg   <= ST_SEP;
                        tx_byte_reg <= 8'h20;
                     end else begin
                        state_reg    <= ST_IDLE;
                        tx_valid_reg <= 1'b0;
                     end
                  end else if (has_suffix) begin
                     state_reg   <= ST_COLON;
                     tx_byte_reg <= 8'h3A;
                  end else begin
                     state_reg   <= TERM_STATE;
                     tx_byte_reg <= TERM_CHAR;
                  end
               end
            end
            ST_SEP: begin
               if (uart_tx_ready) begin
                  state_reg    <= ST_IDLE;
                  tx_valid_reg <= 1'b0;
               end
            end
            ST_COLON: begin
               if (uart_tx_ready) begin
                  state_reg   <= ST_BITS;
                  tx_byte_reg <= {5'b00110, datab_reg[2:0]};
               end
            end
            ST_BITS: begin
               if (uart_tx_ready) begin
                  state_reg   <= TERM_STATE;
                  tx_byte_reg <= TERM_CHAR;
               end
            end
            ST_CR: begin
               if (uart_tx_ready) begin
                  state_reg   <= ST_LF;
                  tx_byte_reg <= 8'h0A;
               end
            end
            ST_LF: begin
               if (uart_tx_ready) begin
                  state_reg    <= ST_IDLE;
                  tx_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= ST_IDLE;
               tx_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_formatter.sv
// Bench for uart_tx_formatter: two instances (default parameters and
// lowercase/no-separator/LF-only), selected one at a time by 'sel'.
module tb_uart_tx_formatter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst    = 1'b1;
   logic       sel    = 1'b0;
   logic       tvalid = 1'b0;
   logic [7:0] tdata  = 8'h00;
   logic [3:0] tdatab = 4'h0;
   logic       tlast  = 1'b0;
   logic       oready = 1'b0;

   logic       tready0, ovalid0, busy0, tready1, ovalid1, busy1;
   logic [7:0] obyte0, obyte1;

   uart_tx_formatter dut0 (
      .clk(clk), .rst(rst),
      .tvalid(tvalid & ~sel), .tready(tready0),
      .tdata(tdata), .tdatab(tdatab), .tlast(tlast),
      .uart_tx_valid(ovalid0), .uart_tx_ready(oready & ~sel),
      .uart_tx_byte(obyte0), .busy(busy0)
   );

   uart_tx_formatter #(.UPPERCASE(1'b0), .SPACE_SEP(1'b0), .CRLF(1'b0)) dut1 (
      .clk(clk), .rst(rst),
      .tvalid(tvalid & sel), .tready(tready1),
      .tdata(tdata), .tdatab(tdatab), .tlast(tlast),
      .uart_tx_valid(ovalid1), .uart_tx_ready(oready & sel),
      .uart_tx_byte(obyte1), .busy(busy1)
   );

   logic       tready_s, ovalid_s, busy_s;
   logic [7:0] obyte_s;
   assign tready_s = sel ? tready1 : tready0;
   assign ovalid_s = sel ? ovalid1 : ovalid0;
   assign busy_s   = sel ? busy1   : busy0;
   assign obyte_s  = sel ? obyte1  : obyte0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int rmode    = 0;   // 0: ready always, 1: random, 2: one cycle in three

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   bit have_prev    = 1'b0;
   int prev_cyc     = 0;
   int prev_gap_exp = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output ready pattern, changed 1 time unit after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      case (rmode)
         0:       oready = 1'b1;
         1:       oready = 1'($urandom_range(0, 1));
         default: oready = (cyc % 3 == 0);
      endcase
   end

   // Output monitor: collect transferred characters and check stall stability.
   initial begin
      bit         stall_prev = 1'b0;
      logic [7:0] byte_prev  = 8'h00;
      forever begin
         @(negedge clk);
         if (stall_prev) begin
            chk("hold_valid", 32'(ovalid_s), 32'd1);
            chk("hold_byte", 32'(obyte_s), 32'(byte_prev));
         end
         stall_prev = !rst && ovalid_s && !oready;
         byte_prev  = obyte_s;
         if (!rst && ovalid_s && oready) begin
            got_q.push_back(obyte_s);
            $display("tx char 0x%02h (inst %0d)", obyte_s, sel);
         end
      end
   end

   // Reference model: characters of one byte of a packet for the selected instance.
   function automatic logic [7:0] hexc(input logic [3:0] n);
      int base = (sel == 1'b0) ? 65 : 97;
      return (n < 10) ? 8'(48 + int'(n)) : 8'(base + int'(n) - 10);
   endfunction

   function automatic bit partial(input logic [3:0] db);
      return (db >= 1) && (db <= 7);
   endfunction

   task automatic model_push(input logic [7:0] d, input logic last, input logic [3:0] db);
      bit fmt_default = (sel == 1'b0);
      exp_q.push_back(hexc(d[7:4]));
      exp_q.push_back(hexc(d[3:0]));
      if (!last) begin
         if (fmt_default) exp_q.push_back(8'h20);
      end else begin
         if (partial(db)) begin
            exp_q.push_back(8'h3A);
            exp_q.push_back(8'(48 + int'(db)));
         end
         if (fmt_default) exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   // Cycles from this byte's input transfer to the next one, ready held high.
   function automatic int gap_of(input logic last, input logic [3:0] db);
      bit fmt_default = (sel == 1'b0);
      int chars;
      if (!last) chars = 2 + (fmt_default ? 1 : 0);
      else       chars = 2 + (partial(db) ? 2 : 0) + (fmt_default ? 2 : 1);
      return chars + 1;
   endfunction

   // Present one byte (called and returning 1 time unit after a rising edge).
   task automatic send_byte(input logic [7:0] d, input logic last, input logic [3:0] db,
                            input int gap, input bit use_model);
      int  t    = 0;
      int  xfer;
      bit  fast = (gap == 0) && (rmode == 0);
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      tvalid = 1'b1; tdata = d; tlast = last; tdatab = db;
      forever begin
         @(negedge clk);
         if (tready_s) break;
         t++;
         if (t > 300) begin
            chk("tready_timeout", 32'd0, 32'd1);
            tvalid = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
      end
      @(posedge clk);
      #1;
      xfer   = cyc;
      tvalid = 1'b0;
      tdata  = 8'($urandom);
      tlast  = 1'($urandom);
      tdatab = 4'($urandom);
      $display("rx byte 0x%02h last=%0d bits=%0d (inst %0d)", d, last, db, sel);
      if (have_prev && fast) chk("gap", 32'(xfer - prev_cyc), 32'(prev_gap_exp));
      have_prev    = (rmode == 0);
      prev_cyc     = xfer;
      prev_gap_exp = gap_of(last, db);
      if (use_model) model_push(d, last, db);
      @(negedge clk);
      chk("lat_valid", 32'(ovalid_s), 32'd1);
      chk("lat_hexh", 32'(obyte_s), 32'(hexc(d[7:4])));
      chk("busy_hi", 32'(busy_s), 32'd1);
      chk("tready_lo", 32'(tready_s), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Wait for the line(s) to finish, then compare collected against expected.
   task automatic drain(input string tag);
      int t = 0;
      while (busy_s || got_q.size() < exp_q.size()) begin
         @(posedge clk);
         #1;
         t++;
         if (t > 3000) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk({tag, "_char"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      @(negedge clk);
      chk({tag, "_busy_lo"}, 32'(busy_s), 32'd0);
      chk({tag, "_tready_hi"}, 32'(tready_s), 32'd1);
      @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      have_prev = 1'b0;
   endtask

   task automatic push_lit(input logic [7:0] c);
      exp_q.push_back(c);
   endtask

   task automatic run_random(input int npkt, input int mode, input bit fast);
      rmode = mode;
      for (int p = 0; p < npkt; p++) begin
         int len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            send_byte(8'($urandom), (i == len - 1), 4'($urandom_range(0, 15)),
                      fast ? 0 : $urandom_range(0, 2), 1'b1);
         end
      end
      drain("rand");
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 32'(tready_s), 32'd0);
      chk("rst_valid", 32'(ovalid_s), 32'd0);
      chk("rst_byte", 32'(obyte_s), 32'h00);
      chk("rst_busy", 32'(busy_s), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tready", 32'(tready_s), 32'd1);
      chk("post_rst_valid", 32'(ovalid_s), 32'd0);
      @(posedge clk);
      #1;

      // Directed burst, ready held high: full/partial/0/9 last-byte cases
      rmode = 0;
      send_byte(8'h3A, 1'b0, 4'd0, 0, 1'b0);
      send_byte(8'hF0, 1'b1, 4'd8, 0, 1'b0);
      send_byte(8'h05, 1'b1, 4'd3, 0, 1'b0);
      send_byte(8'hFF, 1'b1, 4'd0, 0, 1'b0);
      send_byte(8'hFF, 1'b1, 4'd9, 0, 1'b0);
      send_byte(8'h00, 1'b1, 4'd7, 0, 1'b0);
      push_lit(8'h33); push_lit(8'h41); push_lit(8'h20); push_lit(8'h46);
      push_lit(8'h30); push_lit(8'h0D); push_lit(8'h0A);
      push_lit(8'h30); push_lit(8'h35); push_lit(8'h3A); push_lit(8'h33);
      push_lit(8'h0D); push_lit(8'h0A);
      push_lit(8'h46); push_lit(8'h46); push_lit(8'h0D); push_lit(8'h0A);
      push_lit(8'h46); push_lit(8'h46); push_lit(8'h0D); push_lit(8'h0A);
      push_lit(8'h30); push_lit(8'h30); push_lit(8'h3A); push_lit(8'h37);
      push_lit(8'h0D); push_lit(8'h0A);
      drain("burst");

      // Stalled output: ready one cycle in three
      rmode = 2;
      send_byte(8'h12, 1'b0, 4'd0, 0, 1'b0);
      send_byte(8'h34, 1'b1, 4'd8, 0, 1'b0);
      push_lit(8'h31); push_lit(8'h32); push_lit(8'h20); push_lit(8'h33);
      push_lit(8'h34); push_lit(8'h0D); push_lit(8'h0A);
      drain("stall");

      // Reset mid-line, right after the 0x41 character transfer
      rmode = 0;
      send_byte(8'hAB, 1'b0, 4'd0, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(ovalid_s), 32'd0);
      chk("midrst_tready", 32'(tready_s), 32'd1);
      chk("midrst_seen", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("midrst_char", 32'(got_q[0]), 32'h41);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_quiet", 32'(ovalid_s), 32'd0);
      end
      @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      have_prev = 1'b0;
      send_byte(8'h01, 1'b1, 4'd8, 0, 1'b0);
      push_lit(8'h30); push_lit(8'h31); push_lit(8'h0D); push_lit(8'h0A);
      drain("after_rst");

      // Random packets against the reference model, default format
      run_random(6, 0, 1'b1);
      run_random(8, 1, 1'b0);

      // Lowercase, no separator, LF-only instance
      sel   = 1'b1;
      rmode = 0;
      @(posedge clk);
      #1;
      send_byte(8'hAB, 1'b0, 4'd0, 0, 1'b0);
      send_byte(8'hCD, 1'b1, 4'd8, 0, 1'b0);
      send_byte(8'h9E, 1'b1, 4'd2, 0, 1'b0);
      push_lit(8'h61); push_lit(8'h62); push_lit(8'h63); push_lit(8'h64);
      push_lit(8'h0A);
      push_lit(8'h39); push_lit(8'h65); push_lit(8'h3A); push_lit(8'h32);
      push_lit(8'h0A);
      drain("alt");
      run_random(5, 0, 1'b1);
      run_random(6, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
